// File: rtl/branch_predict_if.sv
// D/E-stage signal bundle for the gshare branch predictor.
// The slave modport is the predictor side; master is the pipeline side.
interface branch_predict_if;
    logic [31:0] pcD;
    logic        branchD;
    logic        pred_takeD;
    logic        stallE;
    logic        flushE;
    logic        actual_takeE;
    logic        branchE;
    logic        pred_takeE;
    logic        mispredictE;
    logic [31:0] branch_cnt;
    logic [31:0] miss_cnt;

    modport master (
        output pcD, branchD, stallE, flushE, actual_takeE,
        input  pred_takeD, branchE, pred_takeE, mispredictE, branch_cnt, miss_cnt
    );

    modport slave (
        input  pcD, branchD, stallE, flushE, actual_takeE,
        output pred_takeD, branchE, pred_takeE, mispredictE, branch_cnt, miss_cnt
    );
endinterface

// File: rtl/branch_predict.sv
// gshare direction predictor: predicts the branch in D, resolves it in E,
// trains a table of 2-bit saturating counters and a non-speculative global history.
module branch_predict #(
    parameter int          IDX_BITS       = 10,
    parameter int          GHR_BITS       = 8,
    // Reset value of branch_cnt; anything other than zero is for bring-up only.
    parameter logic [31:0] BRANCH_CNT_RST = 32'h0
) (
    input  logic            clk,
    input  logic            rst,
    branch_predict_if.slave bp
);
    localparam int PHT_SIZE = 1 << IDX_BITS;

    logic [1:0]          pht_q [PHT_SIZE];
    logic [1:0]          pht_d [PHT_SIZE];
    logic [GHR_BITS-1:0] ghr_q, ghr_d;
    logic                branch_e_q, branch_e_d;
    logic                pred_e_q, pred_e_d;
    logic [IDX_BITS-1:0] idx_e_q, idx_e_d;
    logic [31:0]         branch_cnt_q, branch_cnt_d;
    logic [31:0]         miss_cnt_q, miss_cnt_d;

    logic [IDX_BITS-1:0] idx_rd;
    logic                pred_rd;
    logic                commit;
    logic                mispredict;
    logic [1:0]          cnt_old;
    logic [1:0]          cnt_new;
    logic [GHR_BITS:0]   ghr_shift;
    logic                unused_pc;

    assign unused_pc = ^{bp.pcD[31:IDX_BITS+2], bp.pcD[1:0]};

    // D-side lookup reads the registered table, so a same-cycle commit is not bypassed.
    always_comb begin
        idx_rd  = bp.pcD[IDX_BITS+1:2] ^ IDX_BITS'(ghr_q);
        pred_rd = bp.branchD & pht_q[idx_rd][1];
    end

    always_comb begin
        commit     = branch_e_q & ~bp.stallE;
        mispredict = branch_e_q & (pred_e_q ^ bp.actual_takeE);

        branch_e_d = branch_e_q;
        pred_e_d   = pred_e_q;
        idx_e_d    = idx_e_q;
        if (bp.flushE) begin
            branch_e_d = 1'b0;
            pred_e_d   = 1'b0;
        end else if (!bp.stallE) begin
            branch_e_d = bp.branchD;
            pred_e_d   = pred_rd;
            idx_e_d    = idx_rd;
        end
    end

    always_comb begin
        cnt_old = pht_q[idx_e_q];
        cnt_new = cnt_old;
        if (bp.actual_takeE && cnt_old != 2'b11) begin
            cnt_new = cnt_old + 2'b01;
        end else if (!bp.actual_takeE && cnt_old != 2'b00) begin
            cnt_new = cnt_old - 2'b01;
        end

        // Width-generic shift so a one-bit history still works.
        ghr_shift = {ghr_q, bp.actual_takeE};

        pht_d        = pht_q;
        ghr_d        = ghr_q;
        branch_cnt_d = branch_cnt_q;
        miss_cnt_d   = miss_cnt_q;
        if (commit) begin
            pht_d[idx_e_q] = cnt_new;
            ghr_d          = ghr_shift[GHR_BITS-1:0];
            branch_cnt_d   = branch_cnt_q + 32'd1;
            if (mispredict) begin
                miss_cnt_d = miss_cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < PHT_SIZE; i++) begin
                pht_q[i] <= 2'b01;
            end
            ghr_q        <= '0;
            branch_e_q   <= 1'b0;
            pred_e_q     <= 1'b0;
            idx_e_q      <= '0;
            branch_cnt_q <= BRANCH_CNT_RST;
            miss_cnt_q   <= '0;
        end else begin
            pht_q        <= pht_d;
            ghr_q        <= ghr_d;
            branch_e_q   <= branch_e_d;
            pred_e_q     <= pred_e_d;
            idx_e_q      <= idx_e_d;
            branch_cnt_q <= branch_cnt_d;
            miss_cnt_q   <= miss_cnt_d;
        end
    end

    assign bp.pred_takeD  = pred_rd;
    assign bp.branchE     = branch_e_q;
    assign bp.pred_takeE  = pred_e_q;
    assign bp.mispredictE = mispredict;
    assign bp.branch_cnt  = branch_cnt_q;
    assign bp.miss_cnt    = miss_cnt_q;
endmodule
